// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared constants and types for the decode-stage hazard
// scoreboard controller.
package hazard_scoreboard_ctrl_pkg;

  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         MULDIV_LAT_DEF   = 8;
  localparam int         MAX_INFLIGHT_DEF = 3;
  localparam int         NREGS_DEF        = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_ctrl_sb_counter.sv
// One per-register in-flight write counter: saturating
// up/down with an underflow strobe on a retire at zero.
module sb_counter #(
  parameter int CW  = 2,
  parameter int MAX = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          underflow_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count; simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q != CW'(MAX)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        underflow_o = 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage sequencer: issue/stall/squash decision from a
// register scoreboard and the mult/div busy-window FSM.
module hazard_scoreboard_ctrl
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int MULDIV_LAT   = MULDIV_LAT_DEF,
  parameter int NREGS        = NREGS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_in,
  input  logic [4:0] rt_in,
  input  logic       use_rs_in,
  input  logic       use_rt_in,
  input  logic [4:0] dest_in,
  input  logic       dest_en_in,
  input  logic       use_hilo_in,
  input  logic       muldiv_start_in,
  input  logic       flush_in,
  input  logic [4:0] wb_dest_in,
  input  logic       wb_en_in,
  output logic       stall_out,
  output logic       bubble_out,
  output logic       issue_out,
  output logic       muldiv_busy_out,
  output logic       hilo_valid_out,
  output logic       err_underflow_out
);

  localparam int CW = cw_of(MAX_INFLIGHT + 1);
  localparam int LW = cw_of(MULDIV_LAT);

  logic [CW-1:0] cnt_w [32];
  logic [31:0]   uf_w;

  logic          raw_hz;
  logic          hilo_hz;
  logic          md_hz;
  logic          sat_hz;

  md_state_e     state_q;
  md_state_e     state_d;
  logic [LW-1:0] lat_q;
  logic [LW-1:0] lat_d;
  logic          err_q;

  genvar r;
  for (r = 0; r < 32; r++) begin : g_sb
    if (r == 0 || r >= NREGS) begin : g_zero
      assign cnt_w[r] = '0;
      assign uf_w[r]  = 1'b0;
    end else begin : g_cnt
      logic inc;
      logic dec;
      assign inc = issue_out & dest_en_in
                 & (dest_in == 5'(r));
      assign dec = wb_en_in & (wb_dest_in == 5'(r));
      sb_counter #(
        .CW (CW),
        .MAX(MAX_INFLIGHT)
      ) u_cnt (
        .clk_i      (clk),
        .rst_i      (reset),
        .inc_i      (inc),
        .dec_i      (dec),
        .cnt_o      (cnt_w[r]),
        .underflow_o(uf_w[r])
      );
    end
  end

  // Hazard detection uses registered counts only, no bypass.
  always_comb begin
    raw_hz  = (use_rs_in && rs_in != REG_ZERO
               && cnt_w[rs_in] != '0)
            | (use_rt_in && rt_in != REG_ZERO
               && cnt_w[rt_in] != '0);
    hilo_hz = use_hilo_in & (state_q != MD_IDLE);
    md_hz   = muldiv_start_in & (state_q != MD_IDLE);
    sat_hz  = dest_en_in && dest_in != REG_ZERO
              && cnt_w[dest_in] == CW'(MAX_INFLIGHT);
  end

  // Squash wins over stall; nothing leaves decode in reset.
  assign stall_out  = !flush_in
                    & (raw_hz | hilo_hz | md_hz | sat_hz);
  assign issue_out  = !reset & !flush_in & !stall_out;
  assign bubble_out = flush_in | stall_out;

  // Mult/div window: BUSY counts down, DONE pulses once.
  always_comb begin
    state_d         = state_q;
    lat_d           = lat_q;
    muldiv_busy_out = (state_q != MD_IDLE);
    hilo_valid_out  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (issue_out && muldiv_start_in) begin
          state_d = MD_BUSY;
          lat_d   = LW'(MULDIV_LAT - 2);
        end
      end
      MD_BUSY: begin
        if (lat_q == '0) begin
          state_d = MD_DONE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      MD_DONE: begin
        hilo_valid_out = 1'b1;
        state_d        = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // FSM, latency counter and sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      err_q   <= err_q | (|uf_w);
    end
  end

  assign err_underflow_out = err_q;

endmodule
